// File: rtl/cardinal_nic_if.sv
// CPU register-bus and router-port signals of one Cardinal mesh node NIC.
// The slave modport is the NIC's view; the master modport is the CPU/router side.
interface cardinal_nic_if #(
   parameter int DATA_W = 64
);
   logic [1:0]        addr;
   logic [DATA_W-1:0] d_in;
   logic              nicEn;
   logic              nicWrEn;
   logic [DATA_W-1:0] d_out;
   logic              net_si;
   logic              net_ri;
   logic [DATA_W-1:0] net_di;
   logic              net_so;
   logic              net_ro;
   logic [DATA_W-1:0] net_do;
   logic              net_polarity;

   modport slave (
      input  addr, d_in, nicEn, nicWrEn,
      output d_out,
      input  net_si, net_di,
      output net_ri,
      input  net_ro, net_polarity,
      output net_so, net_do
   );

   modport master (
      output addr, d_in, nicEn, nicWrEn,
      input  d_out,
      output net_si, net_di,
      input  net_ri,
      output net_ro, net_polarity,
      input  net_so, net_do
   );
endinterface

// File: rtl/cardinal_nic.sv
// Network interface: input/output packet FIFOs between a cardinal_cpu data port and
// its router port, exposed as four memory-mapped registers with VC-polarity gated injection.
module cardinal_nic #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input logic           clk,
   input logic           reset,
   cardinal_nic_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      REG_IN_DATA    = 2'd0,
      REG_IN_STATUS  = 2'd1,
      REG_OUT_DATA   = 2'd2,
      REG_OUT_STATUS = 2'd3
   } reg_addr_e;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   logic [DATA_W-1:0] in_mem  [DEPTH];
   logic [DATA_W-1:0] out_mem [DEPTH];
   logic [PTR_W-1:0]  in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
   logic [CNT_W-1:0]  in_count, out_count;

   logic in_empty, in_full, out_empty, out_full;
   logic cpu_rd, cpu_wr;
   logic in_push, in_pop, out_push, out_pop;
   logic [DATA_W-1:0] out_head;
   logic [DATA_W-1:0] rd_data;
   reg_addr_e         reg_sel;

   assign reg_sel   = reg_addr_e'(bus.addr);
   assign in_empty  = (in_count == '0);
   assign in_full   = (in_count == CNT_W'(DEPTH));
   assign out_empty = (out_count == '0);
   assign out_full  = (out_count == CNT_W'(DEPTH));

   assign cpu_rd = bus.nicEn & ~bus.nicWrEn;
   assign cpu_wr = bus.nicEn & bus.nicWrEn;

   // Full/empty are sampled before the edge, so a full FIFO refuses a push even when
   // it is popped in the same cycle, and a pop of an empty FIFO never sees the new word.
   assign bus.net_ri = reset & ~in_full;
   assign in_push    = bus.net_si & bus.net_ri;
   assign in_pop     = cpu_rd & (reg_sel == REG_IN_DATA) & ~in_empty;
   assign out_push   = cpu_wr & (reg_sel == REG_OUT_DATA) & ~out_full;

   assign out_head   = out_empty ? '0 : out_mem[out_rd_ptr];
   assign bus.net_do = out_head;
   assign bus.net_so = ~out_empty & bus.net_ro & (out_head[0] == bus.net_polarity);
   assign out_pop    = bus.net_so;

   // NOTE: storage arrays carry no reset; the pointers and counts alone define which
   // entries are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wr_ptr]   <= bus.net_di;
      if (out_push) out_mem[out_wr_ptr] <= bus.d_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_wr_ptr  <= '0;
         in_rd_ptr  <= '0;
         in_count   <= '0;
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_count  <= '0;
      end else begin
         if (in_push)  in_wr_ptr  <= inc_ptr(in_wr_ptr);
         if (in_pop)   in_rd_ptr  <= inc_ptr(in_rd_ptr);
         if (out_push) out_wr_ptr <= inc_ptr(out_wr_ptr);
         if (out_pop)  out_rd_ptr <= inc_ptr(out_rd_ptr);
         in_count  <= in_count + CNT_W'(in_push) - CNT_W'(in_pop);
         out_count <= out_count + CNT_W'(out_push) - CNT_W'(out_pop);
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_IN_DATA:    rd_data = in_empty ? '0 : in_mem[in_rd_ptr];
         REG_IN_STATUS:  rd_data[DATA_W-1] = ~in_empty;
         REG_OUT_STATUS: rd_data[DATA_W-1] = out_full;
         default:        rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      bus.d_out <= '0;
      else if (cpu_rd) bus.d_out <= rd_data;
   end
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic (DATA_W=64, DEPTH=2).
module tb_cardinal_nic;
   localparam int DATA_W = 64;
   localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;

   cardinal_nic_if #(.DATA_W(DATA_W)) bus ();

   cardinal_nic #(.DATA_W(DATA_W), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [1:0] a);
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
      tick();
      bus.nicEn = 1'b0;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = d;
      tick();
      bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
   endtask

   task automatic router_push(input logic [DATA_W-1:0] d);
      bus.net_si = 1'b1; bus.net_di = d;
      tick();
      bus.net_si = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      total++; if (bus.net_ri !== 1'b0) $display("FAIL rst_net_ri got=%b exp=0", bus.net_ri); else passed++;
      total++; if (bus.d_out !== '0) $display("FAIL rst_d_out got=%h exp=0", bus.d_out); else passed++;
      tick();
      reset = 1'b1;
      #1;
      total++; if (bus.net_ri !== 1'b1) $display("FAIL rel_net_ri got=%b exp=1", bus.net_ri); else passed++;
      total++; if (bus.net_so !== 1'b0) $display("FAIL rel_net_so got=%b exp=0", bus.net_so); else passed++;
      cpu_read(2'd1);
      total++; if (bus.d_out !== '0) $display("FAIL rel_in_status got=%h exp=0", bus.d_out); else passed++;
   endtask

   task automatic test_input_fifo();
      router_push(64'hA5);
      router_push(64'hB6);
      total++; if (bus.net_ri !== 1'b0) $display("FAIL in_full_ri got=%b exp=0", bus.net_ri); else passed++;
      cpu_read(2'd1);
      total++; if (bus.d_out !== MSB) $display("FAIL in_status got=%h exp=%h", bus.d_out, MSB); else passed++;
      // Full FIFO refuses C7 although the CPU pops in the same cycle.
      bus.net_si = 1'b1; bus.net_di = 64'hC7;
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = 2'd0;
      tick();
      bus.net_si = 1'b0;
      total++; if (bus.d_out !== 64'hA5) $display("FAIL in_pop0 got=%h exp=a5", bus.d_out); else passed++;
      tick();
      total++; if (bus.d_out !== 64'hB6) $display("FAIL in_pop1 got=%h exp=b6", bus.d_out); else passed++;
      tick();
      bus.nicEn = 1'b0;
      total++; if (bus.d_out !== '0) $display("FAIL in_pop_empty got=%h exp=0", bus.d_out); else passed++;
      total++; if (bus.net_ri !== 1'b1) $display("FAIL in_ri_again got=%b exp=1", bus.net_ri); else passed++;
   endtask

   task automatic test_vc_polarity();
      bus.net_polarity = 1'b0; bus.net_ro = 1'b1;
      cpu_write(2'd2, 64'h01);
      tick();
      total++; if (bus.net_so !== 1'b0) $display("FAIL vc_stall_so got=%b exp=0", bus.net_so); else passed++;
      total++; if (bus.net_do !== 64'h01) $display("FAIL vc_stall_do got=%h exp=1", bus.net_do); else passed++;
      bus.net_polarity = 1'b1;
      #1;
      total++; if (bus.net_so !== 1'b1) $display("FAIL vc_match_so got=%b exp=1", bus.net_so); else passed++;
      tick();
      total++; if (bus.net_so !== 1'b0) $display("FAIL vc_after_so got=%b exp=0", bus.net_so); else passed++;
      total++; if (bus.net_do !== '0) $display("FAIL vc_after_do got=%h exp=0", bus.net_do); else passed++;
   endtask

   task automatic test_output_full();
      bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
      cpu_write(2'd2, 64'h10);
      cpu_write(2'd2, 64'h22);
      cpu_read(2'd3);
      total++; if (bus.d_out !== MSB) $display("FAIL out_status got=%h exp=%h", bus.d_out, MSB); else passed++;
      cpu_read(2'd2);
      total++; if (bus.d_out !== '0) $display("FAIL rd_addr2 got=%h exp=0", bus.d_out); else passed++;
      cpu_write(2'd2, 64'h34);
      bus.net_ro = 1'b1;
      #1;
      total++; if ({bus.net_so, bus.net_do} !== {1'b1, 64'h10}) $display("FAIL out_pkt0 got=%b/%h exp=1/10", bus.net_so, bus.net_do); else passed++;
      tick();
      total++; if ({bus.net_so, bus.net_do} !== {1'b1, 64'h22}) $display("FAIL out_pkt1 got=%b/%h exp=1/22", bus.net_so, bus.net_do); else passed++;
      tick();
      total++; if ({bus.net_so, bus.net_do} !== {1'b0, 64'h0}) $display("FAIL out_drained got=%b/%h exp=0/0", bus.net_so, bus.net_do); else passed++;
   endtask

   task automatic test_simultaneous();
      bus.net_si = 1'b1; bus.net_di = 64'hD8;
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = 2'd0;
      tick();
      bus.net_si = 1'b0; bus.nicEn = 1'b0;
      total++; if (bus.d_out !== '0) $display("FAIL sim_pop_empty got=%h exp=0", bus.d_out); else passed++;
      cpu_read(2'd0);
      total++; if (bus.d_out !== 64'hD8) $display("FAIL sim_word_kept got=%h exp=d8", bus.d_out); else passed++;
   endtask

   task automatic test_reset_midop();
      router_push(64'hE1);
      bus.net_polarity = 1'b0; bus.net_ro = 1'b1;
      cpu_write(2'd2, 64'hF1);
      cpu_read(2'd1);
      total++; if (bus.net_do !== 64'hF1) $display("FAIL pre_rst_do got=%h exp=f1", bus.net_do); else passed++;
      bus.net_polarity = 1'b1; bus.net_ro = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      total++; if ({bus.net_ri, bus.net_so} !== 2'b00) $display("FAIL mid_rst_ri_so got=%b exp=00", {bus.net_ri, bus.net_so}); else passed++;
      total++; if (bus.net_do !== '0) $display("FAIL mid_rst_do got=%h exp=0", bus.net_do); else passed++;
      total++; if (bus.d_out !== '0) $display("FAIL mid_rst_d_out got=%h exp=0", bus.d_out); else passed++;
      tick();
      reset = 1'b1;
      bus.net_ro = 1'b1;
      cpu_read(2'd1);
      total++; if (bus.d_out !== '0) $display("FAIL post_rst_in_status got=%h exp=0", bus.d_out); else passed++;
      cpu_read(2'd0);
      total++; if (bus.d_out !== '0) $display("FAIL post_rst_in_pop got=%h exp=0", bus.d_out); else passed++;
      total++; if (bus.net_so !== 1'b0) $display("FAIL post_rst_so got=%b exp=0", bus.net_so); else passed++;
      bus.net_ro = 1'b0;
      cpu_write(2'd2, 64'h50);
      cpu_write(2'd2, 64'h60);
      cpu_read(2'd3);
      total++; if (bus.d_out !== MSB) $display("FAIL post_rst_refill got=%h exp=%h", bus.d_out, MSB); else passed++;
   endtask

   initial begin
      reset = 1'b0;
      bus.addr = '0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
      bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
      test_reset();
      test_input_fifo();
      test_vc_polarity();
      test_output_full();
      test_simultaneous();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
